// File: rtl/match_controller.sv
// One-round fight sequencer: idle, countdown, timed fight, round-over.
// Arbitrates hits between both players, drives their stunmodes, tracks health and the winner.
module match_controller #(
  parameter int PLAYER_WIDTH     = 64,
  parameter int I_REACH          = 32,
  parameter int D_REACH          = 48,
  parameter int MAX_HEALTH       = 5,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int ROUND_SECONDS    = 60,
  parameter int FRAMES_PER_SEC   = 60
) (
  input  logic       clk_60Hz,
  input  logic       reset,
  input  logic       frame_en,
  input  logic       start,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  input  logic [9:0] p1_pos_x,
  input  logic [9:0] p2_pos_x,
  output logic [1:0] p1_stunmode,
  output logic [1:0] p2_stunmode,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic [6:0] round_timer,
  output logic [1:0] match_state,
  output logic       players_reset,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_COUNTDOWN  = 2'd1,
    S_FIGHT      = 2'd2,
    S_ROUND_OVER = 2'd3
  } state_t;

  localparam int CNT_W = $clog2((COUNTDOWN_FRAMES > FRAMES_PER_SEC) ? COUNTDOWN_FRAMES : FRAMES_PER_SEC);

  localparam logic [3:0] ST_BACK     = 4'd2;
  localparam logic [3:0] ST_I_ACTIVE = 4'd4;
  localparam logic [3:0] ST_D_ACTIVE = 4'd7;

  localparam logic [1:0] SM_NONE  = 2'b00;
  localparam logic [1:0] SM_HIT   = 2'b01;
  localparam logic [1:0] SM_BLOCK = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       p1_sm_q, p1_sm_d, p2_sm_q, p2_sm_d;
  logic [2:0]       p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
  logic [6:0]       timer_q, timer_d;
  logic             pr_q, pr_d;
  logic [1:0]       winner_q, winner_d;
  logic             p1_done_q, p1_done_d, p2_done_q, p2_done_d;

  logic [10:0] gap_raw, gap;
  logic        p1_hit, p2_hit;

  function automatic logic in_reach(input logic [3:0] st, input logic [10:0] g);
    return ((st == ST_I_ACTIVE) && (g <= 11'(I_REACH))) ||
           ((st == ST_D_ACTIVE) && (g <= 11'(D_REACH)));
  endfunction

  function automatic logic [2:0] apply_dmg(input logic [2:0] hp, input logic [3:0] st);
    logic [2:0] dmg;
    dmg = (st == ST_D_ACTIVE) ? 3'd2 : 3'd1;
    return (hp > dmg) ? hp - dmg : 3'd0;
  endfunction

  always_comb begin
    // Both players measure against the same gap because P1 is always on the left.
    gap_raw = {1'b0, p2_pos_x} - ({1'b0, p1_pos_x} + 11'(PLAYER_WIDTH));
    gap     = gap_raw[10] ? 11'd0 : gap_raw;
    p1_hit  = !p1_done_q && in_reach(p1_state, gap);
    p2_hit  = !p2_done_q && in_reach(p2_state, gap);

    state_d   = state_q;
    cnt_d     = cnt_q;
    p1_sm_d   = p1_sm_q;
    p2_sm_d   = p2_sm_q;
    p1_hp_d   = p1_hp_q;
    p2_hp_d   = p2_hp_q;
    timer_d   = timer_q;
    pr_d      = pr_q;
    winner_d  = winner_q;
    p1_done_d = p1_done_q;
    p2_done_d = p2_done_q;

    if (frame_en) begin
      case (state_q)
        S_IDLE, S_ROUND_OVER: begin
          if (start) begin
            state_d  = S_COUNTDOWN;
            cnt_d    = '0;
            p1_hp_d  = 3'(MAX_HEALTH);
            p2_hp_d  = 3'(MAX_HEALTH);
            timer_d  = 7'(ROUND_SECONDS);
            winner_d = 2'b00;
          end
        end
        S_COUNTDOWN: begin
          if (cnt_q == CNT_W'(COUNTDOWN_FRAMES - 1)) begin
            state_d = S_FIGHT;
            cnt_d   = '0;
            pr_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // End-of-round looks at the registered health/timer, one frame after they change.
          if ((p1_hp_q == 3'd0) || (p2_hp_q == 3'd0) || (timer_q == 7'd0)) begin
            state_d   = S_ROUND_OVER;
            pr_d      = 1'b1;
            p1_sm_d   = SM_NONE;
            p2_sm_d   = SM_NONE;
            p1_done_d = 1'b0;
            p2_done_d = 1'b0;
            cnt_d     = '0;
            if (p1_hp_q > p2_hp_q)      winner_d = 2'b01;
            else if (p2_hp_q > p1_hp_q) winner_d = 2'b10;
            else                        winner_d = 2'b11;
          end else begin
            p1_sm_d = SM_NONE;
            p2_sm_d = SM_NONE;
            if (p1_hit) begin
              p2_sm_d = (p2_state == ST_BACK) ? SM_BLOCK : SM_HIT;
              if (p2_state != ST_BACK) p2_hp_d = apply_dmg(p2_hp_q, p1_state);
            end
            if (p2_hit) begin
              p1_sm_d = (p1_state == ST_BACK) ? SM_BLOCK : SM_HIT;
              if (p1_state != ST_BACK) p1_hp_d = apply_dmg(p1_hp_q, p2_state);
            end
            p1_done_d = p1_hit || (p1_done_q && ((p1_state == ST_I_ACTIVE) || (p1_state == ST_D_ACTIVE)));
            p2_done_d = p2_hit || (p2_done_q && ((p2_state == ST_I_ACTIVE) || (p2_state == ST_D_ACTIVE)));
            if (cnt_q == CNT_W'(FRAMES_PER_SEC - 1)) begin
              cnt_d   = '0;
              timer_d = (timer_q != 7'd0) ? timer_q - 1'b1 : 7'd0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_60Hz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p1_sm_q   <= SM_NONE;
      p2_sm_q   <= SM_NONE;
      p1_hp_q   <= 3'(MAX_HEALTH);
      p2_hp_q   <= 3'(MAX_HEALTH);
      timer_q   <= 7'(ROUND_SECONDS);
      pr_q      <= 1'b1;
      winner_q  <= 2'b00;
      p1_done_q <= 1'b0;
      p2_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p1_sm_q   <= p1_sm_d;
      p2_sm_q   <= p2_sm_d;
      p1_hp_q   <= p1_hp_d;
      p2_hp_q   <= p2_hp_d;
      timer_q   <= timer_d;
      pr_q      <= pr_d;
      winner_q  <= winner_d;
      p1_done_q <= p1_done_d;
      p2_done_q <= p2_done_d;
    end
  end

  assign match_state   = state_q;
  assign p1_stunmode   = p1_sm_q;
  assign p2_stunmode   = p2_sm_q;
  assign p1_health     = p1_hp_q;
  assign p2_health     = p2_hp_q;
  assign round_timer   = timer_q;
  assign players_reset = pr_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed round scenarios plus randomized play,
// checked every cycle against a frame-level behavioural model.
module tb_match_controller;

  localparam int PLAYER_WIDTH     = 64;
  localparam int I_REACH          = 32;
  localparam int D_REACH          = 48;
  localparam int MAX_HEALTH       = 5;
  localparam int COUNTDOWN_FRAMES = 180;
  localparam int ROUND_SECONDS    = 60;
  localparam int FRAMES_PER_SEC   = 60;

  logic       clk_60Hz = 1'b0;
  logic       reset    = 1'b0;
  logic       frame_en = 1'b0;
  logic       start    = 1'b0;
  logic [3:0] p1_state = 4'd0;
  logic [3:0] p2_state = 4'd0;
  logic [9:0] p1_pos_x = 10'd100;
  logic [9:0] p2_pos_x = 10'd190;
  logic [1:0] p1_stunmode, p2_stunmode;
  logic [2:0] p1_health, p2_health;
  logic [6:0] round_timer;
  logic [1:0] match_state;
  logic       players_reset;
  logic [1:0] winner;

  match_controller dut (
    .clk_60Hz     (clk_60Hz),
    .reset        (reset),
    .frame_en     (frame_en),
    .start        (start),
    .p1_state     (p1_state),
    .p2_state     (p2_state),
    .p1_pos_x     (p1_pos_x),
    .p2_pos_x     (p2_pos_x),
    .p1_stunmode  (p1_stunmode),
    .p2_stunmode  (p2_stunmode),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .round_timer  (round_timer),
    .match_state  (match_state),
    .players_reset(players_reset),
    .winner       (winner)
  );

  // clock / reset
  always #5 clk_60Hz = ~clk_60Hz;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // behavioural model: phase, frames spent in phase, health, stun, latches
  int m_phase, m_cd_frames, m_fight_frames, m_timer;
  int m_h1, m_h2, m_sm1, m_sm2, m_win;
  bit m_done1, m_done2;

  function automatic bit can_hit(input int st, input int gap);
    return (st == 4 && gap <= I_REACH) || (st == 7 && gap <= D_REACH);
  endfunction

  function automatic int dmg_of(input int st);
    return (st == 7) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cd_frames = 0; m_fight_frames = 0; m_timer = ROUND_SECONDS;
    m_h1 = MAX_HEALTH; m_h2 = MAX_HEALTH; m_sm1 = 0; m_sm2 = 0; m_win = 0;
    m_done1 = 0; m_done2 = 0;
  endtask

  task automatic model_frame();
    int gap;
    bit hit1, hit2;
    int s1, s2;
    s1 = int'(p1_state);
    s2 = int'(p2_state);
    case (m_phase)
      0, 3: if (start) begin
        m_phase = 1; m_cd_frames = 0; m_h1 = MAX_HEALTH; m_h2 = MAX_HEALTH;
        m_timer = ROUND_SECONDS; m_win = 0;
      end
      1: begin
        m_cd_frames++;
        if (m_cd_frames == COUNTDOWN_FRAMES) begin
          m_phase = 2; m_fight_frames = 0;
        end
      end
      default: begin
        if (m_h1 == 0 || m_h2 == 0 || m_timer == 0) begin
          m_phase = 3; m_sm1 = 0; m_sm2 = 0; m_done1 = 0; m_done2 = 0;
          m_win = (m_h1 > m_h2) ? 1 : (m_h2 > m_h1) ? 2 : 3;
        end else begin
          gap = int'(p2_pos_x) - (int'(p1_pos_x) + PLAYER_WIDTH);
          if (gap < 0) gap = 0;
          hit1 = !m_done1 && can_hit(s1, gap);
          hit2 = !m_done2 && can_hit(s2, gap);
          m_sm2 = hit1 ? ((s2 == 2) ? 2 : 1) : 0;
          m_sm1 = hit2 ? ((s1 == 2) ? 2 : 1) : 0;
          if (hit1 && s2 != 2) begin
            m_h2 = m_h2 - dmg_of(s1);
            if (m_h2 < 0) m_h2 = 0;
          end
          if (hit2 && s1 != 2) begin
            m_h1 = m_h1 - dmg_of(s2);
            if (m_h1 < 0) m_h1 = 0;
          end
          m_done1 = hit1 || (m_done1 && (s1 == 4 || s1 == 7));
          m_done2 = hit2 || (m_done2 && (s2 == 4 || s2 == 7));
          m_fight_frames++;
          m_timer = ROUND_SECONDS - m_fight_frames / FRAMES_PER_SEC;
          if (m_timer < 0) m_timer = 0;
        end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_60Hz or negedge reset);
      if (!reset) model_reset();
      else if (clk_60Hz && frame_en) model_frame();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every negedge once checking is enabled
  initial begin
    forever begin
      @(negedge clk_60Hz);
      if (check_en) begin
        check("match_state",   32'(match_state),   32'(m_phase));
        check("players_reset", 32'(players_reset), (m_phase == 2) ? 32'd0 : 32'd1);
        check("p1_stunmode",   32'(p1_stunmode),   32'(m_sm1));
        check("p2_stunmode",   32'(p2_stunmode),   32'(m_sm2));
        check("p1_health",     32'(p1_health),     32'(m_h1));
        check("p2_health",     32'(p2_health),     32'(m_h2));
        check("round_timer",   32'(round_timer),   32'(m_timer));
        check("winner",        32'(winner),        32'(m_win));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_60Hz);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic strike(input bit from_p1, input int st);
    if (from_p1) p1_state = 4'(st); else p2_state = 4'(st);
    step();
    p1_state = 4'd0;
    p2_state = 4'd0;
    step();
  endtask

  task automatic start_round();
    start = 1'b1;
    step();
    start = 1'b0;
    steps(COUNTDOWN_FRAMES);
  endtask

  int st_tab[6] = '{0, 2, 4, 7, 9, 10};

  initial begin
    int hold1, hold2;
    frame_en = 1'b1;
    steps(2);
    check_en = 1'b1;
    check("lit_reset_state",  32'(match_state),   32'd0);
    check("lit_reset_pr",     32'(players_reset), 32'd1);
    check("lit_reset_health", 32'(p2_health),     32'd5);
    check("lit_reset_timer",  32'(round_timer),   32'd60);
    reset = 1'b1;
    step();

    // countdown with a frame_en freeze in the middle
    start = 1'b1;
    step();
    start = 1'b0;
    check("lit_cd_entry", 32'(match_state), 32'd1);
    steps(50);
    frame_en = 1'b0;
    steps(100);
    check("lit_cd_frozen", 32'(match_state), 32'd1);
    frame_en = 1'b1;
    steps(129);
    check("lit_cd_last", 32'(players_reset), 32'd1);
    step();
    check("lit_fight_state", 32'(match_state),   32'd2);
    check("lit_fight_pr",    32'(players_reset), 32'd0);
    check("lit_fight_timer", 32'(round_timer),   32'd60);

    // neutral attack held two frames: single hit
    p1_state = 4'd4;
    step();
    check("lit_ihit_sm", 32'(p2_stunmode), 32'd1);
    check("lit_ihit_hp", 32'(p2_health),   32'd4);
    step();
    check("lit_ihit_once_sm", 32'(p2_stunmode), 32'd0);
    check("lit_ihit_once_hp", 32'(p2_health),   32'd4);
    p1_state = 4'd0;
    step();

    // directional attack into a backward-holding defender
    p1_state = 4'd7;
    p2_state = 4'd2;
    step();
    check("lit_block_sm", 32'(p2_stunmode), 32'd2);
    check("lit_block_hp", 32'(p2_health),   32'd4);
    p1_state = 4'd0;
    p2_state = 4'd0;
    step();
    p2_pos_x = 10'd213;
    p1_state = 4'd7;
    step();
    check("lit_out_of_reach", 32'(p2_stunmode), 32'd0);
    p1_state = 4'd0;
    step();

    // asynchronous reset in the middle of the fight
    reset = 1'b0;
    #1;
    check("lit_rst_state",  32'(match_state),   32'd0);
    check("lit_rst_hp",     32'(p2_health),     32'd5);
    check("lit_rst_pr",     32'(players_reset), 32'd1);
    step();
    reset = 1'b1;
    step();

    // wear both players to 1 health, then trade at gap 0
    start_round();
    p2_pos_x = 10'd190;
    repeat (4) strike(1'b1, 4);
    repeat (4) strike(1'b0, 4);
    check("lit_pre_trade", 32'({p1_health, p2_health}), 32'({3'd1, 3'd1}));
    p2_pos_x = 10'd164;
    p1_state = 4'd4;
    p2_state = 4'd4;
    step();
    check("lit_trade_sm", 32'({p1_stunmode, p2_stunmode}), 32'({2'b01, 2'b01}));
    check("lit_trade_hp", 32'({p1_health, p2_health}),     32'd0);
    p1_state = 4'd0;
    p2_state = 4'd0;
    step();
    check("lit_trade_over",   32'(match_state), 32'd3);
    check("lit_trade_winner", 32'(winner),      32'd3);

    // timeout with health 5/3
    start_round();
    p2_pos_x = 10'd190;
    strike(1'b1, 7);
    check("lit_dhit_hp", 32'(p2_health), 32'd3);
    for (int i = 0; i < 4000 && match_state != 2'd3; i++) step();
    check("lit_timeout_state",  32'(match_state), 32'd3);
    check("lit_timeout_timer",  32'(round_timer), 32'd0);
    check("lit_timeout_winner", 32'(winner),      32'd1);

    // randomized play
    hold1 = 0;
    hold2 = 0;
    for (int i = 0; i < 6000; i++) begin
      frame_en = ($urandom_range(0, 7) != 0);
      start    = ($urandom_range(0, 15) == 0);
      reset    = (i != 3000);
      if (hold1 == 0) begin
        p1_state = 4'(st_tab[$urandom_range(0, 5)]);
        hold1 = $urandom_range(1, 4);
      end
      if (hold2 == 0) begin
        p2_state = 4'(st_tab[$urandom_range(0, 5)]);
        hold2 = $urandom_range(1, 4);
      end
      hold1--;
      hold2--;
      if ($urandom_range(0, 9) == 0) begin
        p1_pos_x = 10'($urandom_range(0, 400));
        p2_pos_x = p1_pos_x + 10'($urandom_range(0, 150));
      end
      step();
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences a one-round fight: idle, 3 s countdown, timed fight, round-over.
- Arbitrates hits between the two player controllers. Generates each player's stunmode, tracks health, declares the winner.
- Sits above both gameplay controllers. Drives their stunmode inputs and holds them in reset outside the fight.

Parameters:
PLAYER_WIDTH, 64, sprite width in pixels; P1 occupies [p1_pos_x, p1_pos_x+PLAYER_WIDTH).
I_REACH, 32, neutral-attack reach in pixels beyond the attacker's edge.
D_REACH, 48, directional-attack reach in pixels.
MAX_HEALTH, 5, health loaded at round start (fits 3 bits).
COUNTDOWN_FRAMES, 180, countdown length in frames.
ROUND_SECONDS, 60, fight duration in seconds.
FRAMES_PER_SEC, 60, frames per round-timer tick.

Ports:
clk_60Hz  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_en  in  1  frame strobe; all counters and hit logic advance only when high (tie high for 60 Hz operation, key pulse for single-step)
start  in  1  level; sampled in IDLE and ROUND_OVER
p1_state  in  4  P1 state code (0 idle, 2 backward, 4 I-active, 7 D-active, 9 hitstun, 10 blockstun)
p2_state  in  4  P2 state code, same encoding
p1_pos_x  in  10  P1 left edge; P1 is always the left player
p2_pos_x  in  10  P2 left edge
p1_stunmode  out  2  to P1: 00 none, 01 hit, 10 block
p2_stunmode  out  2  to P2, same encoding
p1_health  out  3  P1 health
p2_health  out  3  P2 health
round_timer  out  7  seconds remaining
match_state  out  2  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_OVER
players_reset  out  1  high = hold both player controllers in reset
winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset values: match_state=IDLE, stunmodes=00, health=MAX_HEALTH, round_timer=ROUND_SECONDS, players_reset=1, winner=00. All internal counters and hit_done latches = 0.
- All state updates occur on clk_60Hz edges with frame_en=1. With frame_en=0 every register holds.
- IDLE: start=1 → COUNTDOWN, frame counter cleared.
- COUNTDOWN: players_reset=1. Counts COUNTDOWN_FRAMES enabled frames, then → FIGHT. On entry, health is reloaded, round_timer=ROUND_SECONDS, winner=00.
- FIGHT: players_reset=0.
  - Sub-counter wraps at FRAMES_PER_SEC-1. On each wrap, round_timer decrements, saturating at 0.
  - → ROUND_OVER when either health is 0 or round_timer is 0, evaluated on registered values the frame after the update.
- ROUND_OVER: players_reset=1; stunmodes forced 00.
  - winner is registered on entry: higher health wins; equal health → 11.
  - start=1 → COUNTDOWN.
- Hit detection, FIGHT only:
  - gap = p2_pos_x − (p1_pos_x+PLAYER_WIDTH), computed in 11 bits; a negative result clamps to 0.
  - P1 hits P2 when p1_state=4 and gap≤I_REACH, or p1_state=7 and gap≤D_REACH, and P1's hit_done=0. P2 hits P1 symmetrically.
  - Defender state 2 (backward = holding away) → stunmode 10, no damage. Otherwise → stunmode 01 and damage: 1 for state 4, 2 for state 7. Health saturates at 0.
  - stunmode is registered and asserted for exactly one enabled frame, one frame after the active-state sample.
  - hit_done is set on a connecting hit. It clears when the attacker's state is neither 4 nor 7. Result: one hit per active window.
  - Simultaneous hits (trade): both resolve in the same frame, both take damage. If both reach 0, winner=11.
- reset asserted mid-fight: immediate return to all reset values.

Test Plan:
- Reset low then high, start=1 → COUNTDOWN. players_reset=1 for 180 frames, then FIGHT, round_timer=60, players_reset=0.
- p1_pos_x=100, p2_pos_x=190 (gap 26), p1_state=4 for 2 frames, p2_state=0 → one p2_stunmode=01 pulse, p2_health 5→4 (single hit over the 2-frame window).
- Same positions, p1_state=7, p2_state=2 → p2_stunmode=10, p2_health unchanged. gap=49 with p1_state=7 → no stunmode.
- Both states 4 in the same frame, gap 0, health 1/1 → both stunmodes 01, both health 0, ROUND_OVER, winner=11.
- No hits for 3600 enabled frames → round_timer reaches 0, ROUND_OVER. With health 5/3 → winner=01.
- frame_en held 0 for 100 clocks mid-countdown → no progress. reset pulsed low during FIGHT → IDLE, health 5/5, players_reset=1.
